jac1_regval_uart_tx: RTL

//  Downstream observer of the JAC1 core's reg_val output.
//  - Detects every change of reg_val and queues the new value in a small FIFO.
//  - Serialises each queued value as an 8N1-style UART frame on tx.
//  - Gives board-level visibility of the accumulator without a logic analyser.
//  - Sits beside JAC1_Top in the board top; reg_val is its only data input.

---
 rtl/jac1_pkg.sv | 22 ++
 rtl/jac1_sync_fifo.sv | 51 +++++
 rtl/jac1_regval_uart_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/jac1_pkg.sv
// Shared types and helpers for the JAC1 reg_val UART observer.
package jac1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_LVL     = 1'b0;

  // Ceiling log2, never below 1 so it can always size a counter or pointer.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/jac1_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate count.
module jac1_sync_fifo
  import jac1_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 sys_res_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = clog2(FifoDepth);

  logic [DataWidth-1:0] mem [FifoDepth];
  logic [AW:0]          wp;
  logic [AW:0]          rp;
  logic                 wr_en;
  logic                 rd_en;

  // A write into a full FIFO is legal only when the head leaves the same cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  // Pointer update; reset flushes the queue without touching storage.
  always_ff @(posedge clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
    end
  end

  // Storage write; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jac1_regval_uart_tx.sv
// Watches the JAC1 reg_val bus, queues each new value and sends it out as
// a start / DataWidth data bits LSB first / stop UART frame on tx.
module jac1_regval_uart_tx
  import jac1_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int ClkDiv    = 4,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 sys_res_n,
  input  logic [DataWidth-1:0] reg_val,
  output logic                 tx,
  output logic                 busy,
  output logic                 overflow
);

  localparam int CW = clog2(ClkDiv);
  localparam int IW = clog2(DataWidth);
  localparam logic [CW-1:0] CNT_MAX = CW'(ClkDiv - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DataWidth - 1);

  tx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DataWidth-1:0] shreg;
  logic [DataWidth-1:0] shreg_nx;
  logic [DataWidth-1:0] prev_val;
  logic [DataWidth-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 chg;
  logic                 push;
  logic                 pop;
  logic                 cnt_end;

  // prev_val resets to 0, so a zero first value never counts as a change.
  assign chg     = (reg_val != prev_val);
  assign cnt_end = (cnt == CNT_MAX);
  // Pop when idle, or at the last stop cycle so frames run back to back.
  assign pop     = ~fifo_empty & ((state == IDLE) | ((state == STOP) & cnt_end));
  assign push    = chg & (~fifo_full | pop);
  assign busy    = (state != IDLE) | ~fifo_empty;
  assign shreg_nx = shreg >> 1;

  jac1_sync_fifo #(
    .DataWidth (DataWidth),
    .FifoDepth (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .sys_res_n (sys_res_n),
    .push      (push),
    .pop       (pop),
    .din       (reg_val),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Change detector; a dropped change still advances prev_val.
  always_ff @(posedge clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      prev_val <= '0;
      overflow <= 1'b0;
    end else begin
      prev_val <= reg_val;
      if (chg && !push) overflow <= 1'b1;
    end
  end

  // Frame sequencer; tx is driven from a flop so the line never glitches.
  always_ff @(posedge clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= UART_IDLE_LVL;
    end else begin
      cnt <= ((state == IDLE) || cnt_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= UART_IDLE_LVL;
          if (pop) begin
            shreg <= fifo_dout;
            state <= START;
            tx    <= START_LVL;
          end
        end
        START: begin
          if (cnt_end) begin
            state <= DATA;
            idx   <= '0;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (cnt_end) begin
            if (idx == IDX_MAX) begin
              state <= STOP;
              tx    <= UART_IDLE_LVL;
            end else begin
              idx   <= idx + 1'b1;
              shreg <= shreg_nx;
              tx    <= shreg_nx[0];
            end
          end
        end
        STOP: begin
          if (cnt_end) begin
            if (pop) begin
              shreg <= fifo_dout;
              state <= START;
              tx    <= START_LVL;
            end else begin
              state <= IDLE;
              tx    <= UART_IDLE_LVL;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= UART_IDLE_LVL;
        end
      endcase
    end
  end

endmodule
